// File: rtl/ped_signal_controller.sv
// ped_signal_controller
// Pedestrian crossing controller slaved to a vehicle traffic light. A
// pedestrian request is latched and served on the next rising edge of the
// vehicle red lamp: a steady walk interval, then a flashing don't-walk
// clearance, then a steady don't-walk hold until red ends. Any illegal
// vehicle lamp combination, or red dropping while pedestrians may be in the
// crossing, locks the block into a sticky fault that only reset clears.
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       synchronous, active-low reset
//   enable_i      0 freezes all timing (state, count, flash phase, red history)
//   red_i         vehicle red lamp
//   yellow_i      vehicle yellow lamp
//   green_i       vehicle green lamp
//   ped_button_i  pedestrian request, level-sampled
//   walk_o        walk lamp
//   dont_walk_o   don't-walk lamp, flashes during clearance
//   ped_wait_o    request-pending indicator
//   count_o       remaining cycles in walk/clearance, 0 elsewhere
//   conflict_o    sticky safety fault flag
module ped_signal_controller #(
  parameter int unsigned WALK_CYCLES  = 20,
  parameter int unsigned CLEAR_CYCLES = 8,
  parameter int unsigned FLASH_PERIOD = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       red_i,
  input  logic       yellow_i,
  input  logic       green_i,
  input  logic       ped_button_i,
  output logic       walk_o,
  output logic       dont_walk_o,
  output logic       ped_wait_o,
  output logic [7:0] count_o,
  output logic       conflict_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WALK,
    S_CLEAR,
    S_HOLD,
    S_FAULT
  } state_e;

  localparam logic [7:0] WALK_LOAD  = 8'(WALK_CYCLES - 1);
  localparam logic [7:0] CLEAR_LOAD = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_PERIOD - 1);

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] flash_cnt_q, flash_cnt_d;
  logic       flash_on_q, flash_on_d;
  logic       red_q, red_d;
  logic       pending_q, pending_d;
  logic       lamp_ok;
  logic       red_rise;

  // XOR is 1 for one or three lamps lit; rule out the all-three case.
  assign lamp_ok  = (red_i ^ yellow_i ^ green_i) & ~(red_i & yellow_i & green_i);
  assign red_rise = red_i & ~red_q;

  // Fault detection and button latching run every cycle; everything else
  // advances only on enabled cycles.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    flash_cnt_d = flash_cnt_q;
    flash_on_d  = flash_on_q;
    red_d       = red_q;
    pending_d   = pending_q | ped_button_i;

    if (state_q == S_FAULT) begin
      pending_d = 1'b0;
    end else if (!lamp_ok ||
                 (((state_q == S_WALK) || (state_q == S_CLEAR)) && !red_i)) begin
      state_d   = S_FAULT;
      count_d   = 8'd0;
      pending_d = 1'b0;
    end else if (enable_i) begin
      red_d = red_i;
      case (state_q)
        S_IDLE: begin
          if (pending_q) state_d = S_WAIT;
        end
        S_WAIT: begin
          // A press landing on the same edge is consumed by this service.
          if (red_rise) begin
            state_d   = S_WALK;
            count_d   = WALK_LOAD;
            pending_d = 1'b0;
          end
        end
        S_WALK: begin
          if (count_q == 8'd0) begin
            state_d     = S_CLEAR;
            count_d     = CLEAR_LOAD;
            flash_cnt_d = 8'd0;
            flash_on_d  = 1'b1;
          end else begin
            count_d = count_q - 8'd1;
          end
        end
        S_CLEAR: begin
          if (count_q == 8'd0) begin
            state_d = S_HOLD;
          end else begin
            count_d = count_q - 8'd1;
            if (flash_cnt_q == FLASH_LAST) begin
              flash_cnt_d = 8'd0;
              flash_on_d  = ~flash_on_q;
            end else begin
              flash_cnt_d = flash_cnt_q + 8'd1;
            end
          end
        end
        S_HOLD: begin
          // Only one service per red phase: wait for red to end first.
          if (!red_i) state_d = pending_q ? S_WAIT : S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Lamp outputs are registered from the next-state values so they line up
  // with the state they describe.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      count_q     <= 8'd0;
      flash_cnt_q <= 8'd0;
      flash_on_q  <= 1'b1;
      red_q       <= 1'b0;
      pending_q   <= 1'b0;
      walk_o      <= 1'b0;
      dont_walk_o <= 1'b1;
      conflict_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      red_q       <= red_d;
      pending_q   <= pending_d;
      walk_o      <= (state_d == S_WALK);
      dont_walk_o <= (state_d == S_CLEAR) ? flash_on_d : (state_d != S_WALK);
      conflict_o  <= (state_d == S_FAULT);
    end
  end

  assign count_o    = count_q;
  assign ped_wait_o = pending_q;

endmodule

// File: tb/tb_ped_signal_controller.sv
// tb_ped_signal_controller
// Directed bench for ped_signal_controller at default parameters
// (walk 20, clearance 8, flash half-period 2). Inputs are driven 1 ns after
// each rising edge and outputs are sampled at that same point.
module tb_ped_signal_controller;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       enable = 1'b1;
  logic       red = 1'b0;
  logic       yellow = 1'b0;
  logic       green = 1'b1;
  logic       pedButton = 1'b0;
  logic       walk;
  logic       dontWalk;
  logic       pedWait;
  logic [7:0] count;
  logic       conflict;

  int checks = 0;
  int failures = 0;
  logic [7:0] clearPattern = 8'b1100_1100;

  ped_signal_controller dut (
    .clk_i        (clk),
    .reset_i      (resetN),
    .enable_i     (enable),
    .red_i        (red),
    .yellow_i     (yellow),
    .green_i      (green),
    .ped_button_i (pedButton),
    .walk_o       (walk),
    .dont_walk_o  (dontWalk),
    .ped_wait_o   (pedWait),
    .count_o      (count),
    .conflict_o   (conflict)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, leaving time 1 ns past the last one.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic setLamps(input logic r, input logic y, input logic g);
    red = r;
    yellow = y;
    green = g;
  endtask

  initial begin
    // Reset held for two edges.
    applyStimulus(2);
    checkOutput("rst_walk", {7'd0, walk}, 8'd0);
    checkOutput("rst_dont_walk", {7'd0, dontWalk}, 8'd1);
    checkOutput("rst_ped_wait", {7'd0, pedWait}, 8'd0);
    checkOutput("rst_count", count, 8'd0);
    checkOutput("rst_conflict", {7'd0, conflict}, 8'd0);
    resetN = 1'b1;

    // Normal service with a pause mid-walk.
    pedButton = 1'b1;
    applyStimulus(1);
    pedButton = 1'b0;
    checkOutput("svc_ped_wait_set", {7'd0, pedWait}, 8'd1);
    applyStimulus(1);
    checkOutput("svc_wait_walk", {7'd0, walk}, 8'd0);
    checkOutput("svc_wait_dw", {7'd0, dontWalk}, 8'd1);
    setLamps(1'b1, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("svc_walk_on", {7'd0, walk}, 8'd1);
    checkOutput("svc_walk_dw", {7'd0, dontWalk}, 8'd0);
    checkOutput("svc_walk_count19", count, 8'd19);
    checkOutput("svc_ped_wait_clr", {7'd0, pedWait}, 8'd0);
    for (int c = 18; c >= 0; c--) begin
      if (c == 11) begin
        enable = 1'b0;
        for (int p = 0; p < 10; p++) begin
          applyStimulus(1);
          checkOutput("pause_count", count, 8'd12);
          checkOutput("pause_walk", {7'd0, walk}, 8'd1);
        end
        enable = 1'b1;
      end
      applyStimulus(1);
      checkOutput("svc_walk_count", count, 8'(c));
      checkOutput("svc_walk_lamp", {7'd0, walk}, 8'd1);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1);
      checkOutput("svc_clear_count", count, 8'(7 - i));
      checkOutput("svc_clear_dw", {7'd0, clearPattern[7 - i]}, {7'd0, dontWalk} ^ 8'd0);
      checkOutput("svc_clear_walk", {7'd0, walk}, 8'd0);
    end
    applyStimulus(1);
    checkOutput("svc_hold_dw", {7'd0, dontWalk}, 8'd1);
    checkOutput("svc_hold_count", count, 8'd0);
    checkOutput("svc_hold_walk", {7'd0, walk}, 8'd0);
    setLamps(1'b0, 1'b0, 1'b1);
    applyStimulus(1);
    checkOutput("svc_idle_dw", {7'd0, dontWalk}, 8'd1);
    checkOutput("svc_idle_ped_wait", {7'd0, pedWait}, 8'd0);
    checkOutput("svc_idle_conflict", {7'd0, conflict}, 8'd0);

    // Queued request during walk, served on the following red phase.
    pedButton = 1'b1;
    applyStimulus(1);
    pedButton = 1'b0;
    applyStimulus(1);
    setLamps(1'b1, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("q_walk_count19", count, 8'd19);
    pedButton = 1'b1;
    applyStimulus(1);
    pedButton = 1'b0;
    checkOutput("q_ped_wait_walk", {7'd0, pedWait}, 8'd1);
    checkOutput("q_walk_count18", count, 8'd18);
    applyStimulus(18);
    checkOutput("q_walk_count0", count, 8'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1);
      checkOutput("q_ped_wait_clear", {7'd0, pedWait}, 8'd1);
    end
    applyStimulus(3);
    checkOutput("q_hold_no_reserve", {7'd0, walk}, 8'd0);
    checkOutput("q_hold_ped_wait", {7'd0, pedWait}, 8'd1);
    setLamps(1'b0, 1'b0, 1'b1);
    applyStimulus(1);
    checkOutput("q_wait_walk", {7'd0, walk}, 8'd0);
    checkOutput("q_wait_ped_wait", {7'd0, pedWait}, 8'd1);
    setLamps(1'b1, 1'b0, 1'b0);
    pedButton = 1'b1;
    applyStimulus(1);
    pedButton = 1'b0;
    checkOutput("q_served_walk", {7'd0, walk}, 8'd1);
    checkOutput("q_served_count", count, 8'd19);
    checkOutput("q_press_consumed", {7'd0, pedWait}, 8'd0);

    // Red drops at walk count 5.
    applyStimulus(14);
    checkOutput("drop_count5", count, 8'd5);
    setLamps(1'b0, 1'b1, 1'b0);
    applyStimulus(1);
    checkOutput("drop_walk", {7'd0, walk}, 8'd0);
    checkOutput("drop_dw", {7'd0, dontWalk}, 8'd1);
    checkOutput("drop_conflict", {7'd0, conflict}, 8'd1);
    checkOutput("drop_count", count, 8'd0);
    pedButton = 1'b1;
    setLamps(1'b1, 1'b0, 1'b0);
    applyStimulus(4);
    pedButton = 1'b0;
    checkOutput("drop_sticky", {7'd0, conflict}, 8'd1);
    checkOutput("drop_ped_wait", {7'd0, pedWait}, 8'd0);
    checkOutput("drop_stays_dark", {7'd0, walk}, 8'd0);
    resetN = 1'b0;
    setLamps(1'b0, 1'b0, 1'b1);
    applyStimulus(1);
    checkOutput("drop_reset_conflict", {7'd0, conflict}, 8'd0);
    checkOutput("drop_reset_dw", {7'd0, dontWalk}, 8'd1);
    resetN = 1'b1;

    // Request made while red is already high waits for the next red rise.
    setLamps(1'b1, 1'b0, 1'b0);
    applyStimulus(1);
    pedButton = 1'b1;
    applyStimulus(1);
    pedButton = 1'b0;
    applyStimulus(4);
    checkOutput("late_no_walk", {7'd0, walk}, 8'd0);
    checkOutput("late_ped_wait", {7'd0, pedWait}, 8'd1);
    setLamps(1'b0, 1'b0, 1'b1);
    applyStimulus(1);
    setLamps(1'b1, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("late_walk", {7'd0, walk}, 8'd1);
    checkOutput("late_count", count, 8'd19);

    // Illegal lamp combination in IDLE.
    resetN = 1'b0;
    setLamps(1'b0, 1'b0, 1'b1);
    applyStimulus(1);
    resetN = 1'b1;
    checkOutput("ill_pre_conflict", {7'd0, conflict}, 8'd0);
    setLamps(1'b1, 1'b0, 1'b1);
    applyStimulus(1);
    checkOutput("ill_conflict", {7'd0, conflict}, 8'd1);
    checkOutput("ill_dw", {7'd0, dontWalk}, 8'd1);
    checkOutput("ill_walk", {7'd0, walk}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
